// File: rtl/spi_tx_master.sv
// SPI master transmitter: serialises one DATA_W-bit word per accepted en strobe.
// Latency: cs_n drops on the accept edge; the frame lasts DIV*(2*DATA_W+2) cycles, then done pulses.
// Backpressure: en is accepted only in IDLE; while busy, en is ignored (no queuing).
module spi_tx_master #(
  parameter int DATA_W    = 16,
  parameter int DIV       = 26,
  parameter bit CPOL      = 1'b0,
  parameter bit CPHA      = 1'b0,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              en,
  output logic              busy,
  output logic              done,
  output logic              sclk,
  output logic              dout,
  output logic              cs_n
);

  localparam int DCW = $clog2(DIV + 1);
  localparam int BCW = $clog2(DATA_W + 1);
  localparam logic [DCW-1:0] DIV_LAST = DCW'(DIV - 1);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_W);
  localparam logic [BCW-1:0] BIT_PEN  = BCW'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD
  } state_t;

  state_t            state_q, state_d;
  logic [DCW-1:0]    divcnt_q, divcnt_d;
  logic [BCW-1:0]    bitcnt_q, bitcnt_d;
  logic [DATA_W-1:0] sreg_q, sreg_d;
  logic              sclk_q, sclk_d;
  logic              dout_q, dout_d;
  logic              cs_n_q, cs_n_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              div_end;
  logic [DATA_W-1:0] sreg_nxt;

  // Bit presented on the line for a given shift-register content.
  function automatic logic first_bit(input logic [DATA_W-1:0] v);
    if (MSB_FIRST) begin
      return v[DATA_W-1];
    end
    return v[0];
  endfunction

  // Shift register advanced by one bit in the configured order.
  function automatic logic [DATA_W-1:0] shift_next(input logic [DATA_W-1:0] v);
    if (MSB_FIRST) begin
      return {v[DATA_W-2:0], 1'b0};
    end
    return {1'b0, v[DATA_W-1:1]};
  endfunction

  // State and output registers; reset forces the idle bus levels immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      divcnt_q <= '0;
      bitcnt_q <= '0;
      sreg_q   <= '0;
      sclk_q   <= CPOL;
      dout_q   <= 1'b0;
      cs_n_q   <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      divcnt_q <= divcnt_d;
      bitcnt_q <= bitcnt_d;
      sreg_q   <= sreg_d;
      sclk_q   <= sclk_d;
      dout_q   <= dout_d;
      cs_n_q   <= cs_n_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next-state logic: divider paces every phase, bitcnt counts trailing edges in SHIFT.
  always_comb begin
    state_d  = state_q;
    divcnt_d = divcnt_q;
    bitcnt_d = bitcnt_q;
    sreg_d   = sreg_q;
    sclk_d   = sclk_q;
    dout_d   = dout_q;
    cs_n_d   = cs_n_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    div_end  = (divcnt_q == DIV_LAST);
    sreg_nxt = shift_next(sreg_q);

    case (state_q)
      S_IDLE: begin
        if (en) begin
          sreg_d   = data_in;
          cs_n_d   = 1'b0;
          busy_d   = 1'b1;
          divcnt_d = '0;
          bitcnt_d = '0;
          if (!CPHA) begin
            dout_d = first_bit(data_in);
          end
          state_d = S_SETUP;
        end
      end

      S_SETUP: begin
        if (div_end) begin
          // First leading edge; CPHA=1 launches the first bit here.
          divcnt_d = '0;
          bitcnt_d = '0;
          sclk_d   = ~CPOL;
          if (CPHA) begin
            dout_d = first_bit(sreg_q);
          end
          state_d = S_SHIFT;
        end else begin
          divcnt_d = divcnt_q + 1'b1;
        end
      end

      S_SHIFT: begin
        if (div_end) begin
          divcnt_d = '0;
          if (bitcnt_q == BIT_LAST) begin
            // Half-period of idle SCLK after the last trailing edge has elapsed.
            bitcnt_d = '0;
            state_d  = S_HOLD;
          end else if (sclk_q != CPOL) begin
            // Trailing edge: completes one bit; CPHA=0 launches the next one.
            sclk_d   = CPOL;
            bitcnt_d = bitcnt_q + 1'b1;
            if (!CPHA && (bitcnt_q != BIT_PEN)) begin
              sreg_d = sreg_nxt;
              dout_d = first_bit(sreg_nxt);
            end
          end else begin
            // Leading edge 2..DATA_W; CPHA=1 launches the next bit.
            sclk_d = ~CPOL;
            if (CPHA) begin
              sreg_d = sreg_nxt;
              dout_d = first_bit(sreg_nxt);
            end
          end
        end else begin
          divcnt_d = divcnt_q + 1'b1;
        end
      end

      S_HOLD: begin
        if (div_end) begin
          divcnt_d = '0;
          cs_n_d   = 1'b1;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          dout_d   = 1'b0;
          state_d  = S_IDLE;
        end else begin
          divcnt_d = divcnt_q + 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sclk = sclk_q;
  assign dout = dout_q;
  assign cs_n = cs_n_q;

endmodule

// File: tb/tb_spi_tx_master.sv
// Self-checking bench for spi_tx_master: three configurations driven in turn.
// A scoreboard queue holds expected words; a negedge monitor decodes each frame and checks it.
module tb_spi_tx_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [7:0]  din0, din1;
  logic [15:0] din2;
  logic        en_a   [3];
  logic        busy_a [3];
  logic        done_a [3];
  logic        sclk_a [3];
  logic        dout_a [3];
  logic        cs_n_a [3];

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [1:0]  id;
    logic [15:0] dat;
  } exp_t;
  exp_t exp_q[$];

  // Monitor state per instance
  int          low_cnt[3], busy_cnt[3], rises[3], since_rise[3], hi_cnt[3], frames[3];
  logic [15:0] word[3];
  logic        in_fr[3], p_sclk[3], p_cs[3], p_dout[3];
  bit          gap_chk[3];

  // Instance 0: mode 0, 8 bits, DIV=2, MSB first
  spi_tx_master #(.DATA_W(8), .DIV(2), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b1)) u_m0 (
    .clk(clk), .rst_n(rst_n), .data_in(din0), .en(en_a[0]),
    .busy(busy_a[0]), .done(done_a[0]), .sclk(sclk_a[0]), .dout(dout_a[0]), .cs_n(cs_n_a[0]));

  // Instance 1: mode 3, 8 bits, DIV=2, LSB first
  spi_tx_master #(.DATA_W(8), .DIV(2), .CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b0)) u_m3 (
    .clk(clk), .rst_n(rst_n), .data_in(din1), .en(en_a[1]),
    .busy(busy_a[1]), .done(done_a[1]), .sclk(sclk_a[1]), .dout(dout_a[1]), .cs_n(cs_n_a[1]));

  // Instance 2: mode 0, 16 bits, DIV=1, MSB first
  spi_tx_master #(.DATA_W(16), .DIV(1), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b1)) u_w16 (
    .clk(clk), .rst_n(rst_n), .data_in(din2), .en(en_a[2]),
    .busy(busy_a[2]), .done(done_a[2]), .sclk(sclk_a[2]), .dout(dout_a[2]), .cs_n(cs_n_a[2]));

  function automatic int p_w(input int g);
    return (g == 2) ? 16 : 8;
  endfunction
  function automatic int p_div(input int g);
    return (g == 2) ? 1 : 2;
  endfunction
  function automatic logic p_cpol(input int g);
    return (g == 1);
  endfunction
  function automatic logic p_msb(input int g);
    return (g != 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push_exp(input int g, input logic [15:0] d);
    exp_t e;
    e.id  = 2'(g);
    e.dat = d;
    exp_q.push_back(e);
  endtask

  task automatic drive_din(input int g, input logic [15:0] d);
    case (g)
      0:       din0 = d[7:0];
      1:       din1 = d[7:0];
      default: din2 = d;
    endcase
  endtask

  // One-cycle en strobe; data_in is scrambled right after acceptance.
  task automatic send(input int g, input logic [15:0] d);
    @(negedge clk);
    push_exp(g, d);
    drive_din(g, d);
    en_a[g] = 1'b1;
    @(negedge clk);
    en_a[g] = 1'b0;
    drive_din(g, ~d);
  endtask

  task automatic wait_frames(input int g, input int n);
    int k;
    k = 0;
    while (frames[g] < n && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check($sformatf("frame_count[%0d]", g), 32'(frames[g]), 32'(n));
  endtask

  // Frame decoder and per-cycle protocol checks, sampled away from the active edge.
  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (!rst_n) begin
        in_fr[g]  = 1'b0;
        p_sclk[g] = p_cpol(g);
        p_cs[g]   = 1'b1;
        p_dout[g] = 1'b0;
        hi_cnt[g] = 0;
      end else begin
        if (done_a[g]) begin
          check($sformatf("done_with_cs_rise[%0d]", g), 32'({p_cs[g], cs_n_a[g]}), 32'(2'b01));
        end
        if (p_cs[g] && !cs_n_a[g]) begin
          if (gap_chk[g]) begin
            check($sformatf("cs_high_gap[%0d]", g), 32'(hi_cnt[g]), 32'd1);
          end
          in_fr[g]      = 1'b1;
          low_cnt[g]    = 0;
          busy_cnt[g]   = 0;
          rises[g]      = 0;
          since_rise[g] = 0;
          word[g]       = '0;
        end
        if (!cs_n_a[g]) begin
          hi_cnt[g] = 0;
          low_cnt[g]++;
          if (busy_a[g]) busy_cnt[g]++;
          since_rise[g]++;
          if (!p_sclk[g] && sclk_a[g]) begin
            rises[g]++;
            if (rises[g] > 1) begin
              check($sformatf("sclk_period[%0d]", g), 32'(since_rise[g]), 32'(2 * p_div(g)));
            end
            since_rise[g] = 0;
            if (p_msb(g)) word[g] = {word[g][14:0], dout_a[g]};
            else if (rises[g] <= 16) word[g][4'(rises[g] - 1)] = dout_a[g];
          end
          if (!p_cs[g] && (dout_a[g] !== p_dout[g])) begin
            check($sformatf("dout_on_sclk_fall[%0d]", g), 32'({p_sclk[g], sclk_a[g]}), 32'(2'b10));
          end
        end else begin
          hi_cnt[g]++;
        end
        if (!p_cs[g] && cs_n_a[g] && in_fr[g]) begin
          check($sformatf("sb_nonempty[%0d]", g), 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check($sformatf("sb_id[%0d]", g), 32'(e.id), 32'(g));
            check($sformatf("sb_word[%0d]", g), 32'(word[g]), 32'(e.dat));
          end
          check($sformatf("cs_low_len[%0d]", g), 32'(low_cnt[g]), 32'(p_div(g) * (2 * p_w(g) + 2)));
          check($sformatf("busy_len[%0d]", g), 32'(busy_cnt[g]), 32'(p_div(g) * (2 * p_w(g) + 2)));
          check($sformatf("sclk_rises[%0d]", g), 32'(rises[g]), 32'(p_w(g)));
          check($sformatf("done_at_end[%0d]", g), 32'(done_a[g]), 32'd1);
          check($sformatf("busy_at_end[%0d]", g), 32'(busy_a[g]), 32'd0);
          check($sformatf("sclk_idle[%0d]", g), 32'(sclk_a[g]), 32'(p_cpol(g)));
          check($sformatf("dout_idle[%0d]", g), 32'(dout_a[g]), 32'd0);
          in_fr[g] = 1'b0;
          frames[g]++;
        end
        p_sclk[g] = sclk_a[g];
        p_cs[g]   = cs_n_a[g];
        p_dout[g] = dout_a[g];
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst_n = 1'b0;
    din0  = '0;
    din1  = '0;
    din2  = '0;
    for (int g = 0; g < 3; g++) begin
      en_a[g]    = 1'b0;
      gap_chk[g] = 1'b0;
      frames[g]  = 0;
    end
    #23;
    // Reset values on every instance
    for (int g = 0; g < 3; g++) begin
      check($sformatf("rst_sclk[%0d]", g), 32'(sclk_a[g]), 32'(p_cpol(g)));
      check($sformatf("rst_cs_n[%0d]", g), 32'(cs_n_a[g]), 32'd1);
      check($sformatf("rst_dout[%0d]", g), 32'(dout_a[g]), 32'd0);
      check($sformatf("rst_busy[%0d]", g), 32'(busy_a[g]), 32'd0);
      check($sformatf("rst_done[%0d]", g), 32'(done_a[g]), 32'd0);
    end
    rst_n = 1'b1;

    // Mode 0, A5, plus an en pulse mid-frame that must be ignored
    send(0, 16'h00A5);
    repeat (8) @(negedge clk);
    din0    = 8'h3C;
    en_a[0] = 1'b1;
    @(negedge clk);
    en_a[0] = 1'b0;
    wait_frames(0, 1);
    repeat (50) @(negedge clk);
    check("no_queued_frame", 32'(frames[0]), 32'd1);
    send(0, 16'h00C4);
    wait_frames(0, 2);

    // Mode 3, LSB first
    send(1, 16'h00A5);
    wait_frames(1, 1);
    send(1, 16'h001E);
    wait_frames(1, 2);

    // 16-bit, DIV=1
    send(2, 16'h8001);
    wait_frames(2, 1);
    send(2, 16'h1234);
    wait_frames(2, 2);

    // en held high with data_in changing every cycle: frames every 37 cycles
    base = frames[0];
    @(negedge clk);
    en_a[0] = 1'b1;
    for (int i = 0; i < 75; i++) begin
      din0 = 8'($urandom);
      if (i % 37 == 0) push_exp(0, {8'h00, din0});
      if (i == 5) gap_chk[0] = 1'b1;
      @(negedge clk);
    end
    en_a[0] = 1'b0;
    for (int i = 0; i < 20; i++) begin
      din0 = 8'($urandom);
      @(negedge clk);
    end
    wait_frames(0, base + 3);
    repeat (50) @(negedge clk);
    gap_chk[0] = 1'b0;
    check("held_en_frame_count", 32'(frames[0]), 32'(base + 3));

    // Asynchronous reset in the middle of SHIFT
    base = frames[0];
    @(negedge clk);
    din0    = 8'hFF;
    en_a[0] = 1'b1;
    @(negedge clk);
    en_a[0] = 1'b0;
    repeat (10) @(negedge clk);
    check("pre_rst_cs_n", 32'(cs_n_a[0]), 32'd0);
    check("pre_rst_dout", 32'(dout_a[0]), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_sclk", 32'(sclk_a[0]), 32'd0);
    check("arst_cs_n", 32'(cs_n_a[0]), 32'd1);
    check("arst_dout", 32'(dout_a[0]), 32'd0);
    check("arst_busy", 32'(busy_a[0]), 32'd0);
    check("arst_done", 32'(done_a[0]), 32'd0);
    #24;
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("no_frame_after_abort", 32'(frames[0]), 32'(base));
    send(0, 16'h005A);
    wait_frames(0, base + 1);

    repeat (5) @(negedge clk);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
